// File: rtl/l1b_seq_pkg.sv
// Shared types and sizing for the L1B weight-read sequencer.
// One instance per L1B bank; both instances share these widths.
package l1b_seq_pkg;

    localparam int BANK_CH       = 16;
    localparam int L1B_RAM_DEPTH = 256;
    localparam int AW            = $clog2(L1B_RAM_DEPTH);
    localparam int RD_LAT        = 1;
    localparam int REP_W         = 4;
    localparam int BW            = AW + REP_W + 1;
    localparam int DW            = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [AW-1:0]      base;
        logic [AW-1:0]      stride;
        logic [AW:0]        len;
        logic [REP_W-1:0]   rep;
        logic [BANK_CH-1:0] cs_mask;
        logic [1:0]         dst_sel;
    } l1b_wrd_cmd_t;

endpackage

// File: rtl/l1b_rd_addr_gen.sv
// Row address, beat and pass counters for one weight-broadcast command.
// Each pass restarts at the base row once its last beat has been issued.
module l1b_rd_addr_gen
    import l1b_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic [AW-1:0]    i_load_base,
    input  logic [AW-1:0]    i_base,
    input  logic [AW-1:0]    i_stride,
    input  logic [AW:0]      i_len,
    input  logic [REP_W-1:0] i_rep,
    output logic [AW-1:0]    o_addr,
    output logic             o_last_beat,
    output logic             o_last_pass
);

    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_beat_cnt;
    logic [REP_W-1:0] r_pass_cnt;
    logic [AW:0]      w_len_m1;

    assign w_len_m1    = i_len - (AW+1)'(1);
    assign o_last_beat = (r_beat_cnt == w_len_m1);
    assign o_last_pass = (r_pass_cnt == i_rep);
    assign o_addr      = r_addr;

    // Address wraps naturally at AW bits, matching the RAM depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (i_load) begin
            r_addr     <= i_load_base;
            r_beat_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (i_advance) begin
            if (o_last_beat) begin
                r_addr     <= i_base;
                r_beat_cnt <= '0;
                if (!o_last_pass) begin
                    r_pass_cnt <= r_pass_cnt + REP_W'(1);
                end
            end else begin
                r_addr     <= r_addr + i_stride;
                r_beat_cnt <= r_beat_cnt + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/l1b_weight_rd_seq.sv
// Per-bank weight-read sequencer: turns one broadcast command into a stream
// of chip-select/address reads steered to the cubank weight path.
module l1b_weight_rd_seq
    import l1b_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [AW-1:0]      cmd_base_addr,
    input  logic [AW-1:0]      cmd_stride,
    input  logic [AW:0]        cmd_len,
    input  logic [REP_W-1:0]   cmd_rep,
    input  logic [BANK_CH-1:0] cmd_cs_mask,
    input  logic [1:0]         cmd_dst_sel,
    input  logic               abort,
    input  logic               tcache_data_busy,
    output logic [BANK_CH-1:0] tcache_data_cs,
    output logic               tcache_data_data_we,
    output logic [AW-1:0]      tcache_data_addr,
    output logic               weight_rd_mode,
    output logic [1:0]         mv_cub_dst_sel,
    output logic               seq_busy,
    output logic               seq_done,
    output logic [BW-1:0]      beats_issued
);

    seq_state_t   r_state;
    l1b_wrd_cmd_t r_cmd;
    logic         r_wrmode;
    logic         r_done;
    logic [BW-1:0] r_beats;
    logic [DW-1:0] r_drain_cnt;

    l1b_wrd_cmd_t w_cmd_in;
    logic         w_accept;
    logic         w_issue;
    logic         w_empty;
    logic         w_last_beat;
    logic         w_last_pass;

    assign w_cmd_in = '{base:    cmd_base_addr,
                        stride:  cmd_stride,
                        len:     cmd_len,
                        rep:     cmd_rep,
                        cs_mask: cmd_cs_mask,
                        dst_sel: cmd_dst_sel};

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_issue  = (r_state == RUN) && !tcache_data_busy;
    assign w_empty  = (cmd_len == '0) || (cmd_cs_mask == '0);

    l1b_rd_addr_gen u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_advance   (w_issue),
        .i_load_base (cmd_base_addr),
        .i_base      (r_cmd.base),
        .i_stride    (r_cmd.stride),
        .i_len       (r_cmd.len),
        .i_rep       (r_cmd.rep),
        .o_addr      (tcache_data_addr),
        .o_last_beat (w_last_beat),
        .o_last_pass (w_last_pass)
    );

    // Mode stays high through the drain so the core's registered mode still
    // covers the final returned row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_wrmode    <= 1'b0;
            r_done      <= 1'b0;
            r_beats     <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= w_cmd_in;
                        r_beats <= '0;
                        if (w_empty) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_wrmode <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_beats <= r_beats + BW'(1);
                    end
                    if (abort || (w_issue && w_last_beat && w_last_pass)) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DW'(RD_LAT - 1)) begin
                        r_state  <= DONE;
                        r_wrmode <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tcache_data_cs      = (r_state == RUN) ?
                                 (r_cmd.cs_mask & {BANK_CH{!tcache_data_busy}}) : '0;
    assign tcache_data_data_we = 1'b0;
    assign cmd_ready           = (r_state == IDLE);
    assign seq_busy            = (r_state != IDLE);
    assign seq_done            = r_done;
    assign weight_rd_mode      = r_wrmode;
    assign mv_cub_dst_sel      = r_cmd.dst_sel;
    assign beats_issued        = r_beats;

endmodule

// File: tb/tb_l1b_weight_rd_seq.sv
// Self-checking bench for l1b_weight_rd_seq: directed scenarios plus
// randomized commands checked against an address-stream reference model.
module tb_l1b_weight_rd_seq;
    import l1b_seq_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [AW-1:0]      cmd_base_addr;
    logic [AW-1:0]      cmd_stride;
    logic [AW:0]        cmd_len;
    logic [REP_W-1:0]   cmd_rep;
    logic [BANK_CH-1:0] cmd_cs_mask;
    logic [1:0]         cmd_dst_sel;
    logic               abort;
    logic               tcache_data_busy;
    logic [BANK_CH-1:0] tcache_data_cs;
    logic               tcache_data_data_we;
    logic [AW-1:0]      tcache_data_addr;
    logic               weight_rd_mode;
    logic [1:0]         mv_cub_dst_sel;
    logic               seq_busy;
    logic               seq_done;
    logic [BW-1:0]      beats_issued;

    int errors = 0;
    int checks = 0;
    int obs_done_cyc;

    l1b_weight_rd_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_base_addr       (cmd_base_addr),
        .cmd_stride          (cmd_stride),
        .cmd_len             (cmd_len),
        .cmd_rep             (cmd_rep),
        .cmd_cs_mask         (cmd_cs_mask),
        .cmd_dst_sel         (cmd_dst_sel),
        .abort               (abort),
        .tcache_data_busy    (tcache_data_busy),
        .tcache_data_cs      (tcache_data_cs),
        .tcache_data_data_we (tcache_data_data_we),
        .tcache_data_addr    (tcache_data_addr),
        .weight_rd_mode      (weight_rd_mode),
        .mv_cub_dst_sel      (mv_cub_dst_sel),
        .seq_busy            (seq_busy),
        .seq_done            (seq_done),
        .beats_issued        (beats_issued)
    );

    always #5 clk = ~clk;

    // Model: the command expands into a list of row addresses; each cycle the
    // sequencer either issues the next one (not busy) or holds it (busy).
    task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [AW:0] len, input logic [REP_W-1:0] rep,
                           input logic [BANK_CH-1:0] mask, input logic [1:0] dst,
                           input logic [63:0] busy_bits, input int busy_pct,
                           input int abort_cyc, input bit noise, input string tag);
        logic [AW-1:0]      q[$];
        logic [BANK_CH-1:0] exp_cs;
        logic [2:0]         exp_ctl;
        int  issued;
        int  phase;
        int  drain_left;
        bit  b;
        bit  ended;
        issued     = 0;
        ended      = 0;
        drain_left = RD_LAT;
        obs_done_cyc = -1;
        for (int p = 0; p <= int'(rep); p++)
            for (int i = 0; i < int'(len); i++)
                q.push_back(AW'(int'(base) + i * int'(stride)));
        phase = (len == 0 || mask == 0) ? 2 : 0;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = base; cmd_stride = stride;
        cmd_len = len; cmd_rep = rep; cmd_cs_mask = mask; cmd_dst_sel = dst;
        tcache_data_busy = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s accept_ready got=%b exp=1", tag, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        for (int k = 1; k <= 2000 && !ended; k++) begin
            b = ((k < 64) ? busy_bits[k] : 1'b0) | (int'($urandom_range(99)) < busy_pct);
            tcache_data_busy = b;
            abort = (k == abort_cyc);
            if (noise) begin
                cmd_valid = 1'($urandom_range(1));
                cmd_base_addr = AW'($urandom); cmd_stride = AW'($urandom);
                cmd_len = (AW+1)'($urandom); cmd_rep = REP_W'($urandom);
                cmd_cs_mask = BANK_CH'($urandom); cmd_dst_sel = 2'($urandom);
            end
            @(negedge clk);
            exp_cs  = (phase == 0 && !b) ? mask : '0;
            exp_ctl = {1'b0, 1'b1, (phase == 2)};
            checks++;
            if (tcache_data_cs !== exp_cs) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d cs got=%h exp=%h", tag, k, tcache_data_cs, exp_cs);
            end
            checks++;
            if (weight_rd_mode !== (phase != 2)) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d wrmode got=%b exp=%b", tag, k, weight_rd_mode, phase != 2);
            end
            checks++;
            if ({cmd_ready, seq_busy, seq_done} !== exp_ctl) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d ready/busy/done got=%b exp=%b", tag, k,
                         {cmd_ready, seq_busy, seq_done}, exp_ctl);
            end
            checks++;
            if (beats_issued !== BW'(issued)) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d beats got=%0d exp=%0d", tag, k, beats_issued, issued);
            end
            checks++;
            if (mv_cub_dst_sel !== dst || tcache_data_data_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d dst/we got=%0d/%b exp=%0d/0", tag, k,
                         mv_cub_dst_sel, tcache_data_data_we, dst);
            end
            if (phase == 0) begin
                checks++;
                if (tcache_data_addr !== q[0]) begin
                    errors++;
                    $display("[TB] FAIL %s cyc%0d addr got=%h exp=%h", tag, k, tcache_data_addr, q[0]);
                end
            end
            if (seq_done === 1'b1 && obs_done_cyc < 0) obs_done_cyc = k;
            case (phase)
                0: begin
                    if (!b) begin
                        void'(q.pop_front());
                        issued++;
                    end
                    if (abort || q.size() == 0) phase = 1;
                end
                1: begin
                    drain_left--;
                    if (drain_left == 0) phase = 2;
                end
                default: ended = 1;
            endcase
            @(posedge clk); #1;
        end

        cmd_valid = 1'b0; tcache_data_busy = 1'b0; abort = 1'b0;
        checks++;
        if (!ended) begin
            errors++;
            $display("[TB] FAIL %s timeout waiting for completion", tag);
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, seq_busy, seq_done, weight_rd_mode} !== 4'b1000 ||
            beats_issued !== BW'(issued) || mv_cub_dst_sel !== dst || tcache_data_cs !== '0) begin
            errors++;
            $display("[TB] FAIL %s idle_after rdy/bsy/done/wr=%b beats=%0d dst=%0d cs=%h exp 1000/%0d/%0d/0",
                     tag, {cmd_ready, seq_busy, seq_done, weight_rd_mode}, beats_issued,
                     mv_cub_dst_sel, tcache_data_cs, issued, dst);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; tcache_data_busy = 1'b0;
        cmd_base_addr = '0; cmd_stride = '0; cmd_len = '0; cmd_rep = '0;
        cmd_cs_mask = '0; cmd_dst_sel = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tcache_data_cs !== '0 || tcache_data_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset cs/addr got=%h/%h exp=0/0", tcache_data_cs, tcache_data_addr);
        end
        checks++;
        if ({cmd_ready, seq_busy, seq_done, weight_rd_mode, tcache_data_data_we} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset ctl got=%b exp=10000",
                     {cmd_ready, seq_busy, seq_done, weight_rd_mode, tcache_data_data_we});
        end
        checks++;
        if (mv_cub_dst_sel !== 2'd0 || beats_issued !== '0) begin
            errors++;
            $display("[TB] FAIL reset dst/beats got=%0d/%0d exp=0/0", mv_cub_dst_sel, beats_issued);
        end
    endtask

    task automatic test_basic();
        run_cmd(8'h10, 8'h01, 9'd4, 4'd0, 16'hFFFF, 2'd2, 64'd0, 0, 0, 0, "basic");
        checks++;
        if (obs_done_cyc !== 6) begin
            errors++;
            $display("[TB] FAIL basic done_cycle got=%0d exp=6", obs_done_cyc);
        end
    endtask

    task automatic test_wrap();
        run_cmd(8'hFE, 8'h01, 9'd4, 4'd1, 16'hFFFF, 2'd1, 64'd0, 0, 0, 0, "wrap");
    endtask

    task automatic test_stall();
        run_cmd(8'h10, 8'h01, 9'd4, 4'd0, 16'hFFFF, 2'd2, 64'h6, 0, 0, 0, "stall");
        checks++;
        if (obs_done_cyc !== 8) begin
            errors++;
            $display("[TB] FAIL stall done_cycle got=%0d exp=8", obs_done_cyc);
        end
    endtask

    task automatic test_abort();
        run_cmd(8'h20, 8'h02, 9'd8, 4'd0, 16'h0F0F, 2'd3, 64'd0, 0, 3, 0, "abort");
        checks++;
        if (obs_done_cyc !== 5) begin
            errors++;
            $display("[TB] FAIL abort done_cycle got=%0d exp=5", obs_done_cyc);
        end
    endtask

    task automatic test_empty();
        run_cmd(8'h33, 8'h01, 9'd0, 4'd2, 16'hFFFF, 2'd1, 64'd0, 0, 0, 0, "len0");
        checks++;
        if (obs_done_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL len0 done_cycle got=%0d exp=1", obs_done_cyc);
        end
        run_cmd(8'h44, 8'h01, 9'd5, 4'd0, 16'h0000, 2'd2, 64'd0, 0, 0, 0, "mask0");
        checks++;
        if (obs_done_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL mask0 done_cycle got=%0d exp=1", obs_done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = 8'h40; cmd_stride = 8'h03; cmd_len = 9'd8;
        cmd_rep = 4'd0; cmd_cs_mask = 16'h00F0; cmd_dst_sel = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tcache_data_cs != '0, weight_rd_mode, seq_busy, seq_done, cmd_ready} !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset_mid cs!=0/wr/busy/done/ready got=%b exp=00001",
                     {tcache_data_cs != '0, weight_rd_mode, seq_busy, seq_done, cmd_ready});
        end
        checks++;
        if (beats_issued !== '0 || tcache_data_addr !== '0 || mv_cub_dst_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid beats/addr/dst got=%0d/%h/%0d exp=0/0/0",
                     beats_issued, tcache_data_addr, mv_cub_dst_sel);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid post cyc%0d done/busy got=%b%b exp=00", i, seq_done, seq_busy);
            end
        end
        run_cmd(8'h80, 8'h05, 9'd6, 4'd1, 16'h8001, 2'd1, 64'd0, 0, 0, 0, "after_rst");
    endtask

    task automatic test_random();
        logic [AW:0]        len;
        logic [BANK_CH-1:0] mask;
        int                 ab;
        for (int n = 0; n < 25; n++) begin
            len  = ($urandom_range(9) == 0) ? '0 : (AW+1)'($urandom_range(20, 1));
            mask = ($urandom_range(9) == 0) ? '0 : BANK_CH'($urandom);
            ab   = ($urandom_range(3) == 0) ? int'($urandom_range(30, 1)) : 0;
            run_cmd(AW'($urandom), AW'($urandom), len, REP_W'($urandom_range(3)), mask,
                    2'($urandom), 64'd0, 30, ab, 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_abort();
        test_empty();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
